seq_event_logger: RTL and testbench
===================================

# seq_event_logger

Downstream consumer of the bit-serial sequence detector's `seq_seen` output. It timestamps each detection event against a free-running cycle counter and buffers the timestamps in a small FIFO. Software or a host-side block drains the FIFO through a valid/ready read port. A saturating hit counter and a sticky overflow flag give a lossless event count even when the FIFO drops entries.

## Interface
- `TS_WIDTH`, 16, width of timestamp counter and stored entries
- `DEPTH`, 4, FIFO entries; power of two, ≥2
- `CNT_WIDTH`, 8, width of saturating hit counter

- Clock and reset: `reset` is synchronous, active-high; clock is `clk`.
- `clk`  in  1  clock
- `reset`  in  1  synchronous active-high reset
- `seq_seen`  in  1  detector output, sampled every cycle
- `en`  in  1  logging enable; gates timestamp advance and event capture
- `rd_ready`  in  1  consumer accepts head entry
- `clr_ovf`  in  1  clears sticky overflow
- `rd_valid`  out  1  FIFO non-empty
- `rd_ts`  out  TS_WIDTH  timestamp at FIFO head
- `hit_count`  out  CNT_WIDTH  total events detected, saturating
- `overflow`  out  1  sticky: an event was dropped because the FIFO was full

## Operation
- `ts_cnt`: free-running timestamp counter.
  - +1 per cycle while `en`=1; holds while `en`=0.
  - Wraps from 2^TS_WIDTH−1 to 0 with no flag.
- `seq_prev`: register holding the previous cycle's `seq_seen`.
  - Updates every cycle regardless of `en`.
- Event definition: `seq_seen`=1 AND `seq_prev`=0 AND `en`=1.
  - A rising edge is one event. A multi-cycle high level counts once.
- On an event:
  - Push the current (pre-increment) `ts_cnt` value.
  - Increment `hit_count`. It saturates at 2^CNT_WIDTH−1 and never wraps.
  - Events dropped on overflow still count.
- FIFO:
  - Circular buffer, `DEPTH` entries, log2(DEPTH)+1-bit read/write pointers.
  - Full when the pointers differ only in the MSB.
- Pop: `rd_valid`=1 AND `rd_ready`=1. The head advances next cycle.
  - `rd_ready` while empty has no effect.
- Push when full:
  - With a simultaneous pop: both occur, the entry is stored, count is unchanged.
  - Without a pop: the entry is dropped and `overflow` sets.
- Push when empty: the entry is stored normally.
- `overflow` stays set until `clr_ovf`=1. If a clear and a new drop occur in the same cycle, set wins.
- `en`=0 does not block pops; the FIFO drains normally.

## Timing
- Reset values (cycle after `reset` sampled high):
  - `rd_valid`=0, `rd_ts`=0, `hit_count`=0, `overflow`=0.
  - `ts_cnt`=0, `seq_prev`=0, pointers=0.
- Reset mid-operation: FIFO contents are discarded, all state returns to reset values, and no pop or push occurs in the reset cycle.
- Event sampled at edge N:
  - Entry is visible, `rd_valid`=1, at N+1.
  - `hit_count` updates at N+1.
  - `overflow` sets at N+1 on a drop.
- `rd_ts` and `rd_valid` are registered/pointer-derived with no combinational path from `seq_seen` or `rd_ready`.
- `rd_ts` must stay stable while `rd_valid`=1 and `rd_ready`=0.
- Full throughput: one push and one pop per cycle sustained.
- Combined latency: detector reaches its final state at cycle N → `seq_seen`=1 at N → entry readable at N+1.

## Test plan
- Single event:
  - Stimulus: reset, `en`=1, `seq_seen` pulse high for one cycle when `ts_cnt`=5.
  - Expected: next cycle `rd_valid`=1, `rd_ts`=5, `hit_count`=1. Pop with `rd_ready`=1, then `rd_valid`=0.
- Level versus edge:
  - Stimulus: hold `seq_seen` high for 3 cycles, then a second pulse 2 cycles later.
  - Expected: exactly 2 entries, `hit_count`=2, timestamps differ by 5.
- Overflow:
  - Stimulus: `DEPTH`=4, `rd_ready`=0, 6 isolated pulses.
  - Expected: 4 entries hold the first 4 timestamps in order, `overflow`=1, `hit_count`=6.
  - Then `clr_ovf` → `overflow`=0 and the 4 entries remain readable.
- Full with simultaneous push and pop:
  - Stimulus: FIFO full, an event arrives while `rd_ready`=1.
  - Expected: the oldest entry is popped, the new entry is stored, `overflow` stays 0, occupancy stays 4.
- Enable and reset:
  - Stimulus: `en`=0 with pulses on `seq_seen`.
  - Expected: no pushes, `ts_cnt` frozen, `hit_count` unchanged.
  - Stimulus: assert `reset` with 3 entries queued.
  - Expected: next cycle `rd_valid`=0, `hit_count`=0, `ts_cnt`=0.
- Saturation and wrap:
  - Stimulus: `CNT_WIDTH`=2 with 5 events.
  - Expected: `hit_count` stays at 3.
  - Stimulus: `TS_WIDTH`=4, run 20 cycles, event at cycle 17.
  - Expected: `rd_ts`=1.

Source files
------------

// File: rtl/seq_event_logger.sv
`default_nettype none
// ============================================================================
// Module   : seq_event_logger
// Purpose  : Timestamps rising edges of the sequence detector's seq_seen
//            output against a free-running cycle counter and queues the
//            timestamps in a small circular FIFO. A saturating hit counter
//            and a sticky overflow flag keep the event count exact even when
//            the FIFO has to drop entries.
// Ports    : clk        - clock
//            reset      - synchronous, active-high reset
//            seq_seen   - detector output, sampled every cycle
//            en         - logging enable (timestamp advance + capture)
//            rd_ready   - consumer accepts the head entry
//            clr_ovf    - clears the sticky overflow flag
//            rd_valid   - FIFO holds at least one entry
//            rd_ts      - timestamp at the FIFO head
//            hit_count  - saturating count of all detected events
//            overflow   - sticky: an event was dropped on a full FIFO
// Revision : 1.0 - initial release
// ============================================================================
module seq_event_logger #(
   parameter int TS_WIDTH  = 16,
   parameter int DEPTH     = 4,
   parameter int CNT_WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 seq_seen,
   input  logic                 en,
   input  logic                 rd_ready,
   input  logic                 clr_ovf,
   output logic                 rd_valid,
   output logic [TS_WIDTH-1:0]  rd_ts,
   output logic [CNT_WIDTH-1:0] hit_count,
   output logic                 overflow
);

   // Address width of the storage array; pointers carry one extra wrap bit
   // so that full and empty can be told apart without a separate count.
   localparam int c_aw = $clog2(DEPTH);
   localparam int c_pw = c_aw + 1;

   localparam logic [TS_WIDTH-1:0]  c_ts_one  = TS_WIDTH'(1);
   localparam logic [c_pw-1:0]      c_ptr_one = c_pw'(1);
   localparam logic [CNT_WIDTH-1:0] c_cnt_one = CNT_WIDTH'(1);
   localparam logic [CNT_WIDTH-1:0] c_cnt_max = {CNT_WIDTH{1'b1}};

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   logic [TS_WIDTH-1:0]  r_ts_cnt;
   logic                 r_seq_prev;
   logic [c_pw-1:0]      r_wr_ptr;
   logic [c_pw-1:0]      r_rd_ptr;
   logic [TS_WIDTH-1:0]  r_mem [DEPTH];
   logic [CNT_WIDTH-1:0] r_hit_count;
   logic                 r_overflow;

   // ------------------------------------------------------------------------
   // Combinational control
   // ------------------------------------------------------------------------
   logic            w_event;
   logic            w_empty;
   logic            w_full;
   logic            w_pop;
   logic            w_push;
   logic            w_drop;
   logic [c_aw-1:0] w_wr_idx;
   logic [c_aw-1:0] w_rd_idx;

   always_comb begin
      w_wr_idx = r_wr_ptr[c_aw-1:0];
      w_rd_idx = r_rd_ptr[c_aw-1:0];

      // A sustained high level on seq_seen is a single event: only the
      // 0->1 transition qualifies, and only while logging is enabled.
      w_event  = seq_seen & ~r_seq_prev & en;

      w_empty  = (r_wr_ptr == r_rd_ptr);
      w_full   = (r_wr_ptr[c_aw] != r_rd_ptr[c_aw]) &&
                 (w_wr_idx == w_rd_idx);

      w_pop    = ~w_empty & rd_ready;

      // A pop in the same cycle frees the slot the push needs, so a full
      // FIFO still accepts the new entry when the consumer is reading.
      w_push   = w_event & (~w_full | w_pop);
      w_drop   = w_event & w_full & ~w_pop;
   end

   // ------------------------------------------------------------------------
   // Timestamp counter and edge-detect history
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         r_ts_cnt   <= '0;
         r_seq_prev <= 1'b0;
      end else begin
         // History tracks seq_seen even while disabled so that a level that
         // is already high when en rises is not mistaken for a new edge.
         r_seq_prev <= seq_seen;
         if (en) begin
            r_ts_cnt <= r_ts_cnt + c_ts_one;
         end
      end
   end

   // ------------------------------------------------------------------------
   // FIFO pointers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + c_ptr_one;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + c_ptr_one;
         end
      end
   end

   // ------------------------------------------------------------------------
   // FIFO storage
   // The stored value is the timestamp before this cycle's increment.
   // Clearing the array on reset makes rd_ts read zero out of reset.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (w_push) begin
         r_mem[w_wr_idx] <= r_ts_cnt;
      end
   end

   // ------------------------------------------------------------------------
   // Saturating hit counter: counts every event, including dropped ones.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         r_hit_count <= '0;
      end else if (w_event && (r_hit_count != c_cnt_max)) begin
         r_hit_count <= r_hit_count + c_cnt_one;
      end
   end

   // ------------------------------------------------------------------------
   // Sticky overflow: a drop in the same cycle as a clear keeps it set.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         r_overflow <= 1'b0;
      end else if (w_drop) begin
         r_overflow <= 1'b1;
      end else if (clr_ovf) begin
         r_overflow <= 1'b0;
      end
   end

   // ------------------------------------------------------------------------
   // Outputs: derived only from registered state, so the head entry stays
   // stable while the consumer stalls and no path exists from the inputs.
   // A push never targets the head slot unless the FIFO is empty or a pop
   // is moving the head away in the same cycle.
   // ------------------------------------------------------------------------
   assign rd_valid  = ~w_empty;
   assign rd_ts     = r_mem[w_rd_idx];
   assign hit_count = r_hit_count;
   assign overflow  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_seq_event_logger.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_event_logger
// Purpose  : Self-checking bench for seq_event_logger. Two instances share
//            the same stimulus: one with default widths and one with
//            TS_WIDTH=4 / CNT_WIDTH=2 to exercise wrap and saturation.
//            A queue-based reference model tracks the expected behaviour.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_event_logger;

   localparam int DEPTH = 4;

   logic        clk;
   logic        reset;
   logic        seq_seen;
   logic        en;
   logic        rd_ready;
   logic        clr_ovf;

   logic        rd_valid;
   logic [15:0] rd_ts;
   logic [7:0]  hit_count;
   logic        overflow;

   logic        s_rd_valid;
   logic [3:0]  s_rd_ts;
   logic [1:0]  s_hit_count;
   logic        s_overflow;

   int checks;
   int errors;

   // Reference model state
   int  m_q[$];
   int  m_ts;
   bit  m_prev;
   int  m_hits;
   bit  m_ovf;

   seq_event_logger #(.TS_WIDTH(16), .DEPTH(DEPTH), .CNT_WIDTH(8)) dut (
      .clk       (clk),
      .reset     (reset),
      .seq_seen  (seq_seen),
      .en        (en),
      .rd_ready  (rd_ready),
      .clr_ovf   (clr_ovf),
      .rd_valid  (rd_valid),
      .rd_ts     (rd_ts),
      .hit_count (hit_count),
      .overflow  (overflow)
   );

   seq_event_logger #(.TS_WIDTH(4), .DEPTH(DEPTH), .CNT_WIDTH(2)) dut_small (
      .clk       (clk),
      .reset     (reset),
      .seq_seen  (seq_seen),
      .en        (en),
      .rd_ready  (rd_ready),
      .clr_ovf   (clr_ovf),
      .rd_valid  (s_rd_valid),
      .rd_ts     (s_rd_ts),
      .hit_count (s_hit_count),
      .overflow  (s_overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One clock of the reference model, applying the behavioural rules to
   // the inputs that were stable across this edge.
   function automatic void model_update();
      bit ev;
      bit dropped;
      if (reset) begin
         m_q.delete();
         m_ts   = 0;
         m_prev = 0;
         m_hits = 0;
         m_ovf  = 0;
         return;
      end
      ev      = seq_seen && !m_prev && en;
      dropped = 0;
      if (rd_ready && m_q.size() != 0) void'(m_q.pop_front());
      if (ev) begin
         m_hits++;
         if (m_q.size() < DEPTH) m_q.push_back(m_ts);
         else dropped = 1;
      end
      if (dropped) m_ovf = 1;
      else if (clr_ovf) m_ovf = 0;
      m_prev = seq_seen;
      if (en) m_ts = (m_ts + 1) % 65536;
   endfunction

   task automatic step();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic do_reset();
      seq_seen = 0; en = 0; rd_ready = 0; clr_ovf = 0;
      reset = 1;
      step();
      step();
      reset = 0;
   endtask

   task automatic pulse();
      seq_seen = 1; step();
      seq_seen = 0; step();
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if ({rd_valid, rd_ts, hit_count, overflow} !== 26'd0) begin
         errors++;
         $display("FAIL reset_state: got v=%0b ts=%0d hit=%0d ovf=%0b required all zero",
                  rd_valid, rd_ts, hit_count, overflow);
      end
      checks++;
      if ({s_rd_valid, s_rd_ts, s_hit_count, s_overflow} !== 8'd0) begin
         errors++;
         $display("FAIL reset_state_small: got v=%0b ts=%0d hit=%0d ovf=%0b required all zero",
                  s_rd_valid, s_rd_ts, s_hit_count, s_overflow);
      end
   endtask

   task automatic test_single_event();
      do_reset();
      en = 1;
      while (m_ts != 5) step();
      seq_seen = 1;
      step();
      seq_seen = 0;
      checks++;
      if (rd_valid !== 1'b1 || rd_ts !== 16'd5 || hit_count !== 8'd1) begin
         errors++;
         $display("FAIL single_event: got v=%0b ts=%0d hit=%0d required v=1 ts=5 hit=1",
                  rd_valid, rd_ts, hit_count);
      end
      rd_ready = 1;
      step();
      rd_ready = 0;
      checks++;
      if (rd_valid !== 1'b0) begin
         errors++;
         $display("FAIL single_pop: got rd_valid=%0b required 0", rd_valid);
      end
   endtask

   task automatic test_level_edge();
      logic [15:0] first_ts;
      do_reset();
      en = 1;
      seq_seen = 1; step(); step(); step();
      seq_seen = 0; step(); step();
      seq_seen = 1; step();
      seq_seen = 0; step();
      checks++;
      if (hit_count !== 8'd2 || rd_valid !== 1'b1) begin
         errors++;
         $display("FAIL level_edge_count: got hit=%0d v=%0b required hit=2 v=1",
                  hit_count, rd_valid);
      end
      first_ts = rd_ts;
      rd_ready = 1;
      step();
      checks++;
      if (rd_valid !== 1'b1 || rd_ts - first_ts !== 16'd5) begin
         errors++;
         $display("FAIL level_edge_delta: got v=%0b delta=%0d required v=1 delta=5",
                  rd_valid, rd_ts - first_ts);
      end
      step();
      rd_ready = 0;
      checks++;
      if (rd_valid !== 1'b0) begin
         errors++;
         $display("FAIL level_edge_entries: got rd_valid=%0b after 2 pops required 0", rd_valid);
      end
   endtask

   task automatic test_overflow();
      do_reset();
      en = 1;
      for (int i = 0; i < 6; i++) pulse();
      checks++;
      if (overflow !== 1'b1 || hit_count !== 8'd6) begin
         errors++;
         $display("FAIL overflow_set: got ovf=%0b hit=%0d required ovf=1 hit=6",
                  overflow, hit_count);
      end
      checks++;
      if (s_hit_count !== 2'd3) begin
         errors++;
         $display("FAIL hit_saturate: got %0d required 3", s_hit_count);
      end
      // A clear coinciding with a fresh drop must leave the flag set.
      seq_seen = 1; clr_ovf = 1; step();
      checks++;
      if (overflow !== 1'b1 || hit_count !== 8'd7) begin
         errors++;
         $display("FAIL ovf_set_wins: got ovf=%0b hit=%0d required ovf=1 hit=7",
                  overflow, hit_count);
      end
      seq_seen = 0; step();
      clr_ovf = 0;
      checks++;
      if (overflow !== 1'b0 || s_overflow !== 1'b0) begin
         errors++;
         $display("FAIL ovf_clear: got ovf=%0b small=%0b required 0", overflow, s_overflow);
      end
      rd_ready = 1;
      for (int i = 0; i < DEPTH; i++) begin
         checks++;
         if (rd_valid !== 1'b1 || rd_ts !== 16'(2 * i)) begin
            errors++;
            $display("FAIL ovf_entry%0d: got v=%0b ts=%0d required v=1 ts=%0d",
                     i, rd_valid, rd_ts, 2 * i);
         end
         step();
      end
      rd_ready = 0;
      checks++;
      if (rd_valid !== 1'b0) begin
         errors++;
         $display("FAIL ovf_drained: got rd_valid=%0b required 0", rd_valid);
      end
   endtask

   task automatic test_full_push_pop();
      do_reset();
      en = 1;
      for (int i = 0; i < DEPTH; i++) pulse();
      seq_seen = 1; rd_ready = 1; step();
      seq_seen = 0; rd_ready = 0;
      checks++;
      if (overflow !== 1'b0 || rd_valid !== 1'b1 || rd_ts !== 16'd2) begin
         errors++;
         $display("FAIL full_push_pop: got ovf=%0b v=%0b ts=%0d required ovf=0 v=1 ts=2",
                  overflow, rd_valid, rd_ts);
      end
      rd_ready = 1;
      for (int i = 0; i < DEPTH; i++) begin
         checks++;
         if (rd_valid !== 1'b1 || rd_ts !== 16'(2 * i + 2)) begin
            errors++;
            $display("FAIL full_entry%0d: got v=%0b ts=%0d required v=1 ts=%0d",
                     i, rd_valid, rd_ts, 2 * i + 2);
         end
         step();
      end
      rd_ready = 0;
      checks++;
      if (rd_valid !== 1'b0) begin
         errors++;
         $display("FAIL full_occupancy: got rd_valid=%0b after 4 pops required 0", rd_valid);
      end
   endtask

   task automatic test_enable_and_reset();
      do_reset();
      en = 1; step(); step(); step();
      en = 0;
      for (int i = 0; i < 3; i++) pulse();
      checks++;
      if (rd_valid !== 1'b0 || hit_count !== 8'd0) begin
         errors++;
         $display("FAIL enable_gate: got v=%0b hit=%0d required v=0 hit=0", rd_valid, hit_count);
      end
      en = 1; seq_seen = 1; step();
      seq_seen = 0;
      checks++;
      if (rd_valid !== 1'b1 || rd_ts !== 16'd3) begin
         errors++;
         $display("FAIL ts_frozen: got v=%0b ts=%0d required v=1 ts=3", rd_valid, rd_ts);
      end
      // A level already high when en rises is not a new edge.
      en = 0; step(); seq_seen = 1; step();
      en = 1; step();
      seq_seen = 0; step();
      checks++;
      if (hit_count !== 8'd1) begin
         errors++;
         $display("FAIL enable_level: got hit=%0d required 1", hit_count);
      end
      pulse(); pulse();
      reset = 1; step();
      reset = 0;
      checks++;
      if (rd_valid !== 1'b0 || hit_count !== 8'd0 || overflow !== 1'b0) begin
         errors++;
         $display("FAIL midop_reset: got v=%0b hit=%0d ovf=%0b required 0 0 0",
                  rd_valid, hit_count, overflow);
      end
      seq_seen = 1; step();
      seq_seen = 0;
      checks++;
      if (rd_valid !== 1'b1 || rd_ts !== 16'd0) begin
         errors++;
         $display("FAIL reset_ts_cnt: got v=%0b ts=%0d required v=1 ts=0", rd_valid, rd_ts);
      end
   endtask

   task automatic test_wrap();
      do_reset();
      en = 1;
      while (m_ts != 17) step();
      seq_seen = 1; step();
      seq_seen = 0;
      checks++;
      if (s_rd_valid !== 1'b1 || s_rd_ts !== 4'd1 || rd_ts !== 16'd17) begin
         errors++;
         $display("FAIL ts_wrap: got v=%0b small_ts=%0d ts=%0d required v=1 small_ts=1 ts=17",
                  s_rd_valid, s_rd_ts, rd_ts);
      end
   endtask

   task automatic test_random();
      logic [15:0] exp_ts;
      logic [7:0]  exp_hit;
      logic [1:0]  exp_shit;
      do_reset();
      for (int n = 0; n < 3000; n++) begin
         seq_seen = 1'($urandom_range(0, 1));
         en       = ($urandom_range(0, 7) != 0);
         rd_ready = (n < 1500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
         clr_ovf  = ($urandom_range(0, 15) == 0);
         reset    = ($urandom_range(0, 599) == 0);
         step();
         exp_hit  = 8'((m_hits > 255) ? 255 : m_hits);
         exp_shit = 2'((m_hits > 3) ? 3 : m_hits);
         checks++;
         if (rd_valid !== (m_q.size() != 0) || s_rd_valid !== (m_q.size() != 0)) begin
            errors++;
            $display("FAIL rand_valid@%0d: got %0b/%0b required %0b",
                     n, rd_valid, s_rd_valid, m_q.size() != 0);
         end
         if (m_q.size() != 0) begin
            exp_ts = 16'(m_q[0]);
            checks++;
            if (rd_ts !== exp_ts || s_rd_ts !== exp_ts[3:0]) begin
               errors++;
               $display("FAIL rand_ts@%0d: got %0d/%0d required %0d/%0d",
                        n, rd_ts, s_rd_ts, exp_ts, exp_ts[3:0]);
            end
         end
         checks++;
         if (hit_count !== exp_hit || s_hit_count !== exp_shit) begin
            errors++;
            $display("FAIL rand_hit@%0d: got %0d/%0d required %0d/%0d",
                     n, hit_count, s_hit_count, exp_hit, exp_shit);
         end
         checks++;
         if (overflow !== m_ovf || s_overflow !== m_ovf) begin
            errors++;
            $display("FAIL rand_ovf@%0d: got %0b/%0b required %0b",
                     n, overflow, s_overflow, m_ovf);
         end
      end
      reset = 0;
   endtask

   initial begin
      checks = 0; errors = 0;
      reset = 1; seq_seen = 0; en = 0; rd_ready = 0; clr_ovf = 0;
      m_ts = 0; m_prev = 0; m_hits = 0; m_ovf = 0;
      test_reset();
      test_single_event();
      test_level_edge();
      test_overflow();
      test_full_push_pop();
      test_enable_and_reset();
      test_wrap();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
